// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants at most one pending functional-unit result per cycle
// and broadcasts it, registered, on the common data bus.
// Optional feature macro: CDB_ARB_RR_EN selects round-robin arbitration;
// when undefined the arbiter uses fixed priority (lowest index wins) and the
// rotating pointer register does not exist.
module cdb_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int IW   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ*IW-1:0] req_id,
    input  logic [NREQ-1:0]    req_int,
    output logic [NREQ-1:0]    ack,
    input  logic               cdb_hold,
    input  logic               flush,
    output logic               cdb_valid,
    output logic [DW-1:0]      cdb_data,
    output logic [IW-1:0]      cdb_id,
    output logic               cdb_int,
    output logic               err_id0
);

    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] w_elig;
    logic [PW-1:0]   w_off;
    logic [PW-1:0]   w_win;
    logic            w_any;
    logic [NREQ-1:0] w_ack;
    logic [DW-1:0]   w_data;
    logic [IW-1:0]   w_id;
    logic            w_int;

    logic            r_cdb_valid;
    logic [DW-1:0]   r_cdb_data;
    logic [IW-1:0]   r_cdb_id;
    logic            r_cdb_int;
    logic            r_err_id0;

`ifdef CDB_ARB_RR_EN
    logic [PW-1:0]     r_ptr;
    logic [2*NREQ-1:0] w_dbl;
    logic [2*NREQ-1:0] w_rot;
    logic [PW:0]       w_sum;
`endif

    // Eligible set: requests are masked entirely during reset, flush or consumer stall.
    always_comb begin
        w_elig = req;
        if (rst || flush || cdb_hold) begin
            w_elig = '0;
        end else begin
            w_elig = req;
        end
    end

`ifdef CDB_ARB_RR_EN
    // Round-robin pick: rotate the eligible set so ptr sits at bit 0, take the lowest set bit, un-rotate.
    always_comb begin
        w_dbl = {w_elig, w_elig};
        w_rot = w_dbl >> r_ptr;
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = PW'(i);
            end else begin
                w_off = w_off;
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (PW+1)'(NREQ)) begin
            w_win = PW'(w_sum - (PW+1)'(NREQ));
        end else begin
            w_win = w_sum[PW-1:0];
        end
        w_any = |w_elig;
    end
`else
    // Fixed priority pick: the lowest-indexed eligible unit wins, independent of history.
    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_off = PW'(i);
            end else begin
                w_off = w_off;
            end
        end
        w_win = w_off;
        w_any = |w_elig;
    end
`endif

    // One-hot grant and payload select of the winner (AND-OR mux keyed only by the grant).
    always_comb begin
        w_ack  = '0;
        w_data = '0;
        w_id   = '0;
        w_int  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_ack[i] = w_any && (w_win == PW'(i));
            w_data   = w_data | (req_data[i*DW +: DW] & {DW{w_ack[i]}});
            w_id     = w_id   | (req_id[i*IW +: IW]   & {IW{w_ack[i]}});
            w_int    = w_int  | (req_int[i] & w_ack[i]);
        end
    end

    assign ack = w_ack;

    // Broadcast register: latch the winner's payload; an id-0 winner is consumed but not broadcast.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb_valid <= 1'b0;
            r_cdb_data  <= '0;
            r_cdb_id    <= '0;
            r_cdb_int   <= 1'b0;
            r_err_id0   <= 1'b0;
        end else if (w_any) begin
            r_cdb_valid <= (w_id != '0);
            r_cdb_data  <= w_data;
            r_cdb_id    <= w_id;
            r_cdb_int   <= w_int;
            if (w_id == '0) begin
                r_err_id0 <= 1'b1;
            end else begin
                r_err_id0 <= r_err_id0;
            end
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_ARB_RR_EN
    // Rotating pointer: moves just past the unit granted this cycle, wrapping at NREQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            if (w_win == PW'(NREQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_win + PW'(1);
            end
        end else begin
            r_ptr <= r_ptr;
        end
    end
`endif

    assign cdb_valid = r_cdb_valid;
    assign cdb_data  = r_cdb_data;
    assign cdb_id    = r_cdb_id;
    assign cdb_int   = r_cdb_int;
    assign err_id0   = r_err_id0;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level reference model of the arbitration rules.
module tb_cdb_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IW   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ*IW-1:0] req_id;
    logic [NREQ-1:0]    req_int;
    logic [NREQ-1:0]    ack;
    logic               cdb_hold;
    logic               flush;
    logic               cdb_valid;
    logic [DW-1:0]      cdb_data;
    logic [IW-1:0]      cdb_id;
    logic               cdb_int;
    logic               err_id0;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_ptr;
    logic        m_valid;
    logic [31:0] m_data;
    logic [2:0]  m_id;
    logic        m_int;
    logic        m_err;

    cdb_arbiter #(.NREQ(NREQ), .DW(DW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_id(req_id),
        .req_int(req_int), .ack(ack), .cdb_hold(cdb_hold), .flush(flush),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_id(cdb_id),
        .cdb_int(cdb_int), .err_id0(err_id0)
    );

    always #5 clk = ~clk;

    // winner index the rules select for the current inputs, -1 for none
    function automatic int model_winner();
        int idx;
        if (rst || flush || cdb_hold) return -1;
`ifdef CDB_ARB_RR_EN
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (req[idx]) return idx;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (req[k]) return k;
        end
`endif
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_ack();
        logic [NREQ-1:0] e;
        int w;
        e = '0;
        w = model_winner();
        if (w >= 0) e[w] = 1'b1;
        return e;
    endfunction

    task automatic set_unit(input int u, input logic [2:0] id, input logic [31:0] d, input logic f);
        req_id[u*IW +: IW]   = id;
        req_data[u*DW +: DW] = d;
        req_int[u]           = f;
    endtask

    // advance one clock edge and update the model; returns #1 after the edge
    task automatic tick();
        int w;
        logic [31:0] d;
        logic [2:0]  id;
        logic        f;
        w = model_winner();
        d = '0; id = '0; f = 1'b0;
        if (w >= 0) begin
            d  = req_data[w*DW +: DW];
            id = req_id[w*IW +: IW];
            f  = req_int[w];
        end
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = '0; m_int = 1'b0; m_err = 1'b0;
        end else if (w >= 0) begin
            m_valid = (id != 3'd0);
            m_data  = d;
            m_id    = id;
            m_int   = f;
            if (id == 3'd0) m_err = 1'b1;
            m_ptr   = (w + 1) % NREQ;
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; cdb_hold = 1'b0; flush = 1'b0;
        for (int u = 0; u < NREQ; u++) set_unit(u, 3'(u + 1), 32'h1000_0000 + 32'(u), 1'b1);
        #1;
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        tick();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack2 got=%b exp=0000", ack); end
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", cdb_valid); end
        checks++; if (cdb_id !== 3'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", cdb_id); end
        checks++; if (cdb_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", cdb_data); end
        checks++; if (err_id0 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_id0); end
        rst = 1'b0; req = '0;
    endtask

    task automatic test_single();
        req = 4'b0010;
        set_unit(1, 3'd5, 32'hDEADBEEF, 1'b1);
        #1;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL single_ack got=%b exp=0010", ack); end
        tick();
        req = '0;
        #1;
        checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", cdb_valid); end
        checks++; if (cdb_id !== 3'd5) begin errors++; $display("FAIL single_id got=%0d exp=5", cdb_id); end
        checks++; if (cdb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got=%h exp=deadbeef", cdb_data); end
        checks++; if (cdb_int !== 1'b1) begin errors++; $display("FAIL single_int got=%b exp=1", cdb_int); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_noack got=%b exp=0000", ack); end
        tick();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got=%b exp=0", cdb_valid); end
        checks++; if (cdb_id !== 3'd5) begin errors++; $display("FAIL single_id_hold got=%0d exp=5", cdb_id); end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] exp_ack;
        logic [2:0]      exp_id;
        logic [31:0]     exp_data;
        int              w;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
`ifdef CDB_ARB_RR_EN
            w = c % NREQ;
`else
            w = 0;
`endif
            exp_ack = '0; exp_ack[w] = 1'b1;
            exp_id   = req_id[w*IW +: IW];
            exp_data = req_data[w*DW +: DW];
            checks++; if (ack !== exp_ack) begin errors++; $display("FAIL contention_ack c=%0d got=%b exp=%b", c, ack, exp_ack); end
            tick();
            checks++; if (cdb_valid !== 1'b1 || cdb_id !== exp_id || cdb_data !== exp_data) begin
                errors++; $display("FAIL contention_bcast c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, cdb_valid, cdb_id, cdb_data, exp_id, exp_data);
            end
            set_unit(w, 3'($urandom_range(1, 7)), $urandom, 1'($urandom_range(0, 1)));
        end
        req = '0;
    endtask

    task automatic test_hold_flush();
        do_reset();
        req = 4'b0100; set_unit(2, 3'd3, 32'hCAFE_0002, 1'b0); cdb_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL hold_ack c=%0d got=%b exp=0000", c, ack); end
            tick();
            checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL hold_valid c=%0d got=%b exp=0", c, cdb_valid); end
        end
        cdb_hold = 1'b0; #1;
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL release_ack got=%b exp=0100", ack); end
        tick();
        checks++; if (cdb_valid !== 1'b1 || cdb_id !== 3'd3) begin errors++; $display("FAIL release_bcast got=%b/%0d exp=1/3", cdb_valid, cdb_id); end
        flush = 1'b1; #1;
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL flush_ack got=%b exp=0000", ack); end
        tick();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", cdb_valid); end
        cdb_hold = 1'b1; #1;
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL flushhold_ack got=%b exp=0000", ack); end
        tick();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flushhold_valid got=%b exp=0", cdb_valid); end
        flush = 1'b0; cdb_hold = 1'b0; #1;
`ifdef CDB_ARB_RR_EN
        checks++; if (ack !== model_ack()) begin errors++; $display("FAIL ptr_kept got=%b exp=%b", ack, model_ack()); end
`else
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL ptr_kept got=%b exp=0100", ack); end
`endif
        req = '0;
    endtask

    task automatic test_id0();
        do_reset();
        req = 4'b1000; set_unit(3, 3'd0, 32'h0BAD_0003, 1'b0); #1;
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL id0_ack got=%b exp=1000", ack); end
        tick();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL id0_valid got=%b exp=0", cdb_valid); end
        checks++; if (err_id0 !== 1'b1) begin errors++; $display("FAIL id0_err got=%b exp=1", err_id0); end
        req = 4'b0001; set_unit(0, 3'd2, 32'h0000_1111, 1'b0);
        for (int c = 0; c < 3; c++) tick();
        checks++; if (err_id0 !== 1'b1 || cdb_valid !== 1'b1) begin errors++; $display("FAIL id0_sticky got=%b/%b exp=1/1", err_id0, cdb_valid); end
        do_reset();
        checks++; if (err_id0 !== 1'b0) begin errors++; $display("FAIL id0_clear got=%b exp=0", err_id0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1111;
        for (int u = 0; u < NREQ; u++) set_unit(u, 3'(u + 1), 32'h2000_0000 + 32'(u), 1'b0);
        tick(); tick();
`ifdef CDB_ARB_RR_EN
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL mid_preack got=%b exp=0100", ack); end
`else
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL mid_preack got=%b exp=0001", ack); end
`endif
        rst = 1'b1; #1;
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL mid_rst_ack got=%b exp=0000", ack); end
        tick();
        checks++; if (cdb_valid !== 1'b0 || cdb_data !== 32'd0 || cdb_id !== 3'd0) begin
            errors++; $display("FAIL mid_rst_out got=%b/%h/%0d exp=0/0/0", cdb_valid, cdb_data, cdb_id);
        end
        rst = 1'b0; #1;
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL mid_first got=%b exp=0001", ack); end
        tick();
        req = '0;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] e;
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 49) == 0);
            cdb_hold = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            req      = 4'($urandom);
            for (int u = 0; u < NREQ; u++)
                set_unit(u, ($urandom_range(0, 19) == 0) ? 3'd0 : 3'($urandom_range(1, 7)), $urandom, 1'($urandom_range(0, 1)));
            #1;
            e = model_ack();
            checks++; if (ack !== e) begin errors++; $display("FAIL rand_ack c=%0d got=%b exp=%b", c, ack, e); end
            tick();
            checks++; if (cdb_valid !== m_valid || cdb_data !== m_data || cdb_id !== m_id || cdb_int !== m_int || err_id0 !== m_err) begin
                errors++;
                $display("FAIL rand_out c=%0d got=%b/%h/%0d/%b/%b exp=%b/%h/%0d/%b/%b", c,
                         cdb_valid, cdb_data, cdb_id, cdb_int, err_id0, m_valid, m_data, m_id, m_int, m_err);
            end
        end
        rst = 1'b0; cdb_hold = 1'b0; flush = 1'b0; req = '0;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = '0; req_id = '0; req_int = '0;
        cdb_hold = 1'b0; flush = 1'b0;
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = '0; m_int = 1'b0; m_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_hold_flush();
        test_id0();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the common data bus (CDB) of the multi-segment out-of-order CPU among the functional units (ALU, load unit, branch unit, …) that complete results tagged with a reorder-queue entry id. Each cycle at most one pending result is granted and broadcast, registered, as the `cdbData`/`cdbId`/`cdbInt` triple the reorder queue, reservation stations and `regState` snoop. Sits between the execution units and the CDB; it is the only CDB driver.

## Interface
- `NREQ`, 4, number of requesting units (2..8)
- `DW`, 32, result data width
- `IW`, 3, reorder-queue id width; id 0 is reserved (entries are 1..7)

- `clk` in 1, global clock; all state on rising edge
- `rst` in 1, reset, synchronous, active-high
- `req` in NREQ, per-unit result pending
- `req_data` in NREQ*DW, packed payloads, unit i at `[i*DW +: DW]`
- `req_id` in NREQ*IW, packed reorder-queue ids
- `req_int` in NREQ, per-unit internal-computation flag
- `ack` out NREQ, one-hot grant, combinational, same cycle as acceptance
- `cdb_hold` in 1, consumer stall (reorder-queue write port busy); no grant while high
- `flush` in 1, pipeline flush (mispredict); cancels grant and broadcast
- `cdb_valid` out 1, broadcast valid, registered
- `cdb_data` out DW, broadcast data, registered
- `cdb_id` out IW, broadcast id, registered
- `cdb_int` out 1, broadcast internal flag, registered
- `err_id0` out 1, sticky: a request with id 0 was consumed

## Operation
- Eligible set E = `req` with `rst`, `flush`, `cdb_hold` all low; otherwise `ack` = 0.
- Winner chosen from E (policy per Configuration); `ack[w]` = 1 for exactly that cycle.
- On the edge ending an ack cycle: `cdb_valid`←1 (0 if winner's id is 0), `cdb_data`/`cdb_id`/`cdb_int`←winner's payload; if id = 0, `err_id0`←1.
- Cycle with no ack: `cdb_valid`←0; `cdb_data`/`cdb_id`/`cdb_int` hold last value.
- Requester rule: keep `req` and payload stable until sampled `ack`; drop `req` the cycle after ack unless a new result is ready. Withdrawing `req` before ack is legal; nothing is broadcast for it.
- Round-robin pointer `ptr` (width ceil(log2 NREQ)): on ack of unit w, `ptr`←(w+1) mod NREQ; wraps NREQ-1→0. Unchanged when no ack.
- `flush`: no ack that cycle, `cdb_valid`←0 next edge; `ptr` unchanged. Flush with hold: flush semantics (identical outcome).
- `err_id0` clears only on `rst`.

## Timing
- Reset values: `cdb_valid`=0, `cdb_data`=0, `cdb_id`=0, `cdb_int`=0, `err_id0`=0, `ptr`=0; `ack`=0 while `rst`=1.
- Latency: request accepted in cycle C (ack high) → `cdb_valid`=1 for cycle C+1 only.
- Throughput: one broadcast per cycle; back-to-back grants to different or same unit allowed.
- `rst` mid-operation: next cycle all outputs at reset values; an ack issued in the reset cycle cannot occur; pending requests re-arbitrate from `ptr`=0.
- `ack` is combinational from `req`, `ptr`, `cdb_hold`, `flush`, `rst`; no combinational path from `req_data`/`req_id` to `ack`.

## Configuration
- `CDB_ARB_RR_EN` defined: round-robin; winner = first set bit of E scanning `ptr`, `ptr`+1, …, wrapping.
- Not defined: fixed priority, lowest index wins; `ptr` register omitted (ack behaviour independent of history).

## Test plan
- Reset: assert `rst` with all `req`=1 → `ack`=0; next cycle `cdb_valid`=0, `cdb_id`=0, `err_id0`=0.
- Single unit: `req`=4'b0010, id 5, data 0xDEADBEEF, `req_int`=1 → `ack`=0010 same cycle; next cycle `cdb_valid`=1, `cdb_id`=5, `cdb_data`=0xDEADBEEF, `cdb_int`=1; one cycle later `cdb_valid`=0.
- Contention (`CDB_ARB_RR_EN`): `req`=1111 held 8 cycles, payloads refreshed after each ack → grant order 0,1,2,3,0,1,2,3; without macro → unit 0 every cycle.
- Hold/flush: `req`=0100, `cdb_hold`=1 for 3 cycles → no ack, `cdb_valid`=0; release → ack next cycle, broadcast following cycle. `flush`=1 in ack-eligible cycle → `ack`=0, `cdb_valid`=0 next cycle.
- Id 0: unit 3 requests with id 0 → `ack`=1000, next cycle `cdb_valid`=0, `err_id0`=1 and stays 1 until `rst`.
- Reset mid-stream: `rst` during continuous `req`=1111 after `ptr`=2 → after reset first grant goes to unit 0.
